// File: rtl/bus_fifo_port.sv
// rtl/bus_fifo_port.sv - bus-mapped responder bridging CPU reads/writes to TX/RX stream FIFOs
// Four register words at BASE_ADDRESS: DATA, STATUS, CONTROL, COUNT.
module bus_fifo_port #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = 20'h00400,
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  inout  wire  [DATA_WIDTH-1:0] bus_data,
  input  logic                  read,
  input  logic                  write,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] tx_mem [DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem [DEPTH];
  logic [AW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic overflow, underflow;

  logic hit, rd_hit, wr_hit;
  logic [1:0] offset;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push_req, tx_push, tx_pop, rx_pop_req, rx_pop, rx_push;
  logic flush, clear, overflow_set, underflow_set;
  logic [DATA_WIDTH-1:0] rd_val;

  assign hit    = bus_addr[ADDR_WIDTH-1:2] == BASE_ADDRESS[ADDR_WIDTH-1:2];
  assign offset = bus_addr[1:0];
  // read and write together is treated as no access at all
  assign rd_hit = hit && read && !write;
  assign wr_hit = hit && write && !read;

  assign tx_full  = tx_cnt == CW'(DEPTH);
  assign tx_empty = tx_cnt == '0;
  assign rx_full  = rx_cnt == CW'(DEPTH);
  assign rx_empty = rx_cnt == '0;

  assign flush = wr_hit && offset == 2'd2 && bus_data[1];
  assign clear = wr_hit && offset == 2'd2 && bus_data[0];

  assign tx_push_req   = wr_hit && offset == 2'd0;
  assign tx_push       = tx_push_req && !tx_full && !flush;
  assign tx_pop        = tx_valid && tx_ready && !flush;
  assign overflow_set  = tx_push_req && tx_full;

  assign rx_pop_req    = rd_hit && offset == 2'd0;
  assign rx_pop        = rx_pop_req && !rx_empty && !flush;
  assign underflow_set = rx_pop_req && rx_empty;
  assign rx_push       = rx_valid && rx_ready && !flush;

  assign tx_valid = !tx_empty;
  assign tx_data  = tx_mem[tx_rd];
  assign rx_ready = !rx_full;

  always_comb begin
    rd_val = '0;
    case (offset)
      2'd0: rd_val = rx_empty ? '0 : rx_mem[rx_rd];
      2'd1: rd_val = DATA_WIDTH'({underflow, overflow, rx_empty, rx_full, tx_empty, tx_full});
      2'd2: rd_val = '0;
      2'd3: rd_val = DATA_WIDTH'({8'(rx_cnt), 8'(tx_cnt)});
      default: rd_val = '0;
    endcase
  end

  assign bus_data = rd_hit ? rd_val : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr     <= '0;
      tx_rd     <= '0;
      tx_cnt    <= '0;
      rx_wr     <= '0;
      rx_rd     <= '0;
      rx_cnt    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      // cleared so tx_data reads 0 out of reset
      for (int i = 0; i < DEPTH; i++) tx_mem[i] <= '0;
    end else begin
      if (flush) begin
        tx_wr  <= '0;
        tx_rd  <= '0;
        tx_cnt <= '0;
        rx_wr  <= '0;
        rx_rd  <= '0;
        rx_cnt <= '0;
      end else begin
        if (tx_push) begin
          tx_mem[tx_wr] <= bus_data;
          tx_wr <= tx_wr + AW'(1);
        end
        if (tx_pop) tx_rd <= tx_rd + AW'(1);
        case ({tx_push, tx_pop})
          2'b10:   tx_cnt <= tx_cnt + CW'(1);
          2'b01:   tx_cnt <= tx_cnt - CW'(1);
          default: tx_cnt <= tx_cnt;
        endcase

        if (rx_push) begin
          rx_mem[rx_wr] <= rx_data;
          rx_wr <= rx_wr + AW'(1);
        end
        if (rx_pop) rx_rd <= rx_rd + AW'(1);
        case ({rx_push, rx_pop})
          2'b10:   rx_cnt <= rx_cnt + CW'(1);
          2'b01:   rx_cnt <= rx_cnt - CW'(1);
          default: rx_cnt <= rx_cnt;
        endcase
      end

      // a new error in the same cycle as a clear keeps the flag set
      if (overflow_set)  overflow <= 1'b1;
      else if (clear)    overflow <= 1'b0;
      if (underflow_set) underflow <= 1'b1;
      else if (clear)    underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_fifo_port.sv
// tb/tb_bus_fifo_port.sv - directed self-checking bench for bus_fifo_port
module tb_bus_fifo_port;

  localparam logic [19:0] BASE = 20'h00400;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] bus_addr;
  wire  [15:0] bus_data;
  logic        read, write;
  logic [15:0] tx_data;
  logic        tx_valid, tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid, rx_ready;

  logic [15:0] drv;
  logic        drv_en;
  logic [15:0] d;

  int checks = 0;
  int failures = 0;

  assign bus_data = drv_en ? drv : 16'hzzzz;

  always #5 clk = ~clk;

  bus_fifo_port dut (
    .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_data(bus_data),
    .read(read), .write(write), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [19:0] a, input logic [15:0] v);
    bus_addr = a;
    drv = v;
    drv_en = 1'b1;
    write = 1'b1;
    step();
    write = 1'b0;
    drv_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [19:0] a, output logic [15:0] v);
    bus_addr = a;
    read = 1'b1;
    #1;
    v = bus_data;
    step();
    read = 1'b0;
  endtask

  initial begin
    reset = 1'b1; bus_addr = '0; read = 1'b0; write = 1'b0;
    drv = '0; drv_en = 1'b0; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    step(); step();
    reset = 1'b0;

    // reset state
    chk("reset_tx_valid", 16'(tx_valid), 16'd0);
    chk("reset_tx_data", tx_data, 16'h0000);
    chk("reset_rx_ready", 16'(rx_ready), 16'd1);
    bus_addr = BASE + 20'd3;
    #1;
    checks++;
    assert (bus_data === 16'hzzzz) else begin
      failures++;
      $error("FAIL idle_bus_z observed=%h expected=zzzz", bus_data);
    end
    bus_rd(BASE + 20'd1, d); chk("reset_status", d, 16'h000A);
    bus_rd(BASE + 20'd3, d); chk("reset_count", d, 16'h0000);

    // TX fill past full, then drain
    for (int i = 0; i < 9; i++) bus_wr(BASE, 16'h1111 + 16'(i));
    bus_rd(BASE + 20'd3, d); chk("tx_full_count", d, 16'h0008);
    bus_rd(BASE + 20'd1, d); chk("tx_full_status", d, 16'h0019);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tx_valid_%0d", i), 16'(tx_valid), 16'd1);
      chk($sformatf("tx_data_%0d", i), tx_data, 16'h1111 + 16'(i));
      step();
    end
    chk("tx_drained_valid", 16'(tx_valid), 16'd0);
    tx_ready = 1'b0;

    // RX fill to full, drain past empty
    for (int i = 0; i < 8; i++) begin
      rx_valid = 1'b1;
      rx_data = 16'hA000 + 16'(i);
      chk($sformatf("rx_ready_%0d", i), 16'(rx_ready), 16'd1);
      step();
    end
    rx_valid = 1'b0;
    chk("rx_full_ready", 16'(rx_ready), 16'd0);
    for (int i = 0; i < 8; i++) begin
      bus_rd(BASE, d);
      chk($sformatf("rx_read_%0d", i), d, 16'hA000 + 16'(i));
    end
    bus_rd(BASE, d); chk("rx_underflow_read", d, 16'h0000);
    bus_rd(BASE + 20'd1, d); chk("err_status", d, 16'h003A);
    bus_wr(BASE + 20'd2, 16'h0001);
    bus_rd(BASE + 20'd1, d); chk("cleared_status", d, 16'h000A);
    bus_rd(BASE + 20'd2, d); chk("control_reads_0", d, 16'h0000);

    // simultaneous RX push and bus pop
    rx_valid = 1'b1;
    rx_data = 16'hB000; step();
    rx_data = 16'hB001; step();
    rx_data = 16'hB002;
    bus_rd(BASE, d); chk("simul_pop_data", d, 16'hB000);
    rx_valid = 1'b0;
    bus_rd(BASE + 20'd3, d); chk("simul_count", d, 16'h0200);
    bus_rd(BASE, d); chk("simul_next0", d, 16'hB001);
    bus_rd(BASE, d); chk("simul_next1", d, 16'hB002);
    rx_valid = 1'b1;
    rx_data = 16'hC000;
    bus_rd(BASE, d); chk("empty_simul_data", d, 16'h0000);
    rx_valid = 1'b0;
    bus_rd(BASE + 20'd1, d); chk("empty_simul_status", d, 16'h0022);
    bus_rd(BASE + 20'd3, d); chk("empty_simul_count", d, 16'h0100);

    // flush beats a same-cycle TX pop
    for (int i = 0; i < 5; i++) bus_wr(BASE, 16'hD000 + 16'(i));
    bus_rd(BASE + 20'd3, d); chk("pre_flush_count", d, 16'h0105);
    tx_ready = 1'b1;
    bus_wr(BASE + 20'd2, 16'h0002);
    chk("flush_tx_valid", 16'(tx_valid), 16'd0);
    tx_ready = 1'b0;
    bus_rd(BASE + 20'd3, d); chk("flush_count", d, 16'h0000);

    // reset during an RX stream
    rx_valid = 1'b1;
    rx_data = 16'hE000; step();
    rx_data = 16'hE001; step();
    reset = 1'b1;
    rx_data = 16'hE002; step();
    reset = 1'b0;
    rx_valid = 1'b0;
    bus_rd(BASE + 20'd3, d); chk("reset_mid_count", d, 16'h0000);
    bus_rd(BASE + 20'd1, d); chk("reset_mid_status", d, 16'h000A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
